ac_response_meter: RTL and testbench

Digital receive end of the AC stimulus/filter path in the mixed-signal bench. The block consumes the sampled filter output together with the zero-phase marker of the sinusoidal stimulus, and measures peak, trough and peak-to-peak amplitude over a programmed whole number of stimulus periods. The result is returned on a valid/ready handshake to the sweep controller, which steps frequency and reads one result per point.

---
 rtl/ac_response_meter_if.sv | 32 +++
 rtl/ac_response_meter.sv | 181 ++++++++++++++++++
 tb/tb_ac_response_meter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ac_response_meter_if.sv
// ac_response_meter_if: sweep-controller <-> AC response meter signal bundle.
// master = sweep controller / sample source, slave = meter.
interface ac_response_meter_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned PW = 8,
  parameter int unsigned CW = 24
) ();
  logic                 start;
  logic [PW-1:0]        num_periods;
  logic                 s_valid;
  logic [DW-1:0]        s_data;
  logic                 s_zero;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic [DW-1:0]        res_max;
  logic [DW-1:0]        res_min;
  logic [DW:0]          res_pp;
  logic [CW-1:0]        res_samples;
  logic [DW+CW-1:0]     res_sum;
  logic                 err_ovf;

  modport master (
    output start, num_periods, s_valid, s_data, s_zero, res_ready,
    input  busy, res_valid, res_max, res_min, res_pp, res_samples, res_sum, err_ovf
  );

  modport slave (
    input  start, num_periods, s_valid, s_data, s_zero, res_ready,
    output busy, res_valid, res_max, res_min, res_pp, res_samples, res_sum, err_ovf
  );
endinterface

// File: rtl/ac_response_meter.sv
// ac_response_meter: peak / trough / peak-to-peak measurement over a whole
// number of stimulus periods, delimited by zero-phase marker samples.
// Optional window sum accumulator enabled by defining AC_METER_MEAN_EN.
module ac_response_meter #(
  parameter int unsigned DW = 16,
  parameter int unsigned PW = 8,
  parameter int unsigned CW = 24
) (
  input  logic                clk,
  input  logic                rst,
  ac_response_meter_if.slave  bus
);
  localparam int unsigned RW = DW + 1;
  localparam int unsigned SW = DW + CW;

  typedef enum logic [1:0] {IDLE, ARM, MEAS, HOLD} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        np_q, np_d;
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic signed [DW-1:0] max_q, max_d;
  logic signed [DW-1:0] min_q, min_d;
  logic [CW-1:0]        samp_q, samp_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 rv_q, rv_d;
  logic [DW-1:0]        res_max_q, res_max_d;
  logic [DW-1:0]        res_min_q, res_min_d;
  logic [RW-1:0]        res_pp_q, res_pp_d;
  logic [CW-1:0]        res_samp_q, res_samp_d;
`ifdef AC_METER_MEAN_EN
  logic signed [SW-1:0] sum_q, sum_d;
  logic [SW-1:0]        res_sum_q, res_sum_d;
  logic signed [SW-1:0] smp_ext;
`endif

  logic signed [DW-1:0] smp;
  logic [PW-1:0]        pcnt_inc;
  logic                 samp_full;
  logic [RW-1:0]        pp_c;

  // Next-state and datapath: window tracking plus result capture on HOLD entry
  always_comb begin
    state_d    = state_q;
    np_d       = np_q;
    pcnt_d     = pcnt_q;
    max_d      = max_q;
    min_d      = min_q;
    samp_d     = samp_q;
    ovf_d      = ovf_q;
    res_max_d  = res_max_q;
    res_min_d  = res_min_q;
    res_pp_d   = res_pp_q;
    res_samp_d = res_samp_q;
`ifdef AC_METER_MEAN_EN
    sum_d      = sum_q;
    res_sum_d  = res_sum_q;
`endif

    smp       = signed'(bus.s_data);
    pcnt_inc  = pcnt_q + PW'(1);
    samp_full = (samp_q == {CW{1'b1}});
    // Sign-extend both operands by one bit so the difference never wraps
    pp_c      = RW'({max_q[DW-1], max_q} - {min_q[DW-1], min_q});
`ifdef AC_METER_MEAN_EN
    smp_ext   = {{CW{smp[DW-1]}}, smp};
`endif

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.num_periods != '0)) begin
          np_d    = bus.num_periods;
          state_d = ARM;
        end
      end
      ARM: begin
        if (bus.s_valid && bus.s_zero) begin
          max_d   = smp;
          min_d   = smp;
          samp_d  = CW'(1);
          pcnt_d  = '0;
          ovf_d   = 1'b0;
`ifdef AC_METER_MEAN_EN
          sum_d   = smp_ext;
`endif
          state_d = MEAS;
        end
      end
      MEAS: begin
        if (bus.s_valid) begin
          if (bus.s_zero && (pcnt_inc == np_q)) begin
            // Closing marker: excluded from the window, results captured
            pcnt_d     = pcnt_inc;
            res_max_d  = max_q;
            res_min_d  = min_q;
            res_pp_d   = pp_c;
            res_samp_d = samp_q;
`ifdef AC_METER_MEAN_EN
            res_sum_d  = sum_q;
`endif
            state_d    = HOLD;
          end else begin
            if (bus.s_zero) pcnt_d = pcnt_inc;
            if (smp > max_q) max_d = smp;
            if (smp < min_q) min_d = smp;
            if (samp_full) begin
              ovf_d = 1'b1;
            end else begin
              samp_d = samp_q + CW'(1);
`ifdef AC_METER_MEAN_EN
              sum_d  = sum_q + smp_ext;
`endif
            end
          end
        end
      end
      HOLD: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    rv_d   = (state_d == HOLD);
  end

  // State and result registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      np_q       <= '0;
      pcnt_q     <= '0;
      max_q      <= '0;
      min_q      <= '0;
      samp_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      res_max_q  <= '0;
      res_min_q  <= '0;
      res_pp_q   <= '0;
      res_samp_q <= '0;
`ifdef AC_METER_MEAN_EN
      sum_q      <= '0;
      res_sum_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      np_q       <= np_d;
      pcnt_q     <= pcnt_d;
      max_q      <= max_d;
      min_q      <= min_d;
      samp_q     <= samp_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      res_max_q  <= res_max_d;
      res_min_q  <= res_min_d;
      res_pp_q   <= res_pp_d;
      res_samp_q <= res_samp_d;
`ifdef AC_METER_MEAN_EN
      sum_q      <= sum_d;
      res_sum_q  <= res_sum_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.res_valid   = rv_q;
  assign bus.res_max     = res_max_q;
  assign bus.res_min     = res_min_q;
  assign bus.res_pp      = res_pp_q;
  assign bus.res_samples = res_samp_q;
  assign bus.err_ovf     = ovf_q;
`ifdef AC_METER_MEAN_EN
  assign bus.res_sum     = res_sum_q;
`else
  assign bus.res_sum     = '0;
`endif

endmodule

// File: tb/tb_ac_response_meter.sv
// tb_ac_response_meter: directed bench for ac_response_meter (default widths
// plus a CW=4 instance for counter saturation). Honours AC_METER_MEAN_EN.
module tb_ac_response_meter;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ac_response_meter_if #(.DW(16), .PW(8), .CW(24)) mb ();
  ac_response_meter_if #(.DW(16), .PW(8), .CW(4))  sb ();

  ac_response_meter #(.DW(16), .PW(8), .CW(24)) u_dut (.clk(clk), .rst(rst), .bus(mb.slave));
  ac_response_meter #(.DW(16), .PW(8), .CW(4))  u_sat (.clk(clk), .rst(rst), .bus(sb.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample on the main instance
  task automatic smp(input logic [15:0] d, input logic z);
    mb.s_valid = 1'b1;
    mb.s_data  = d;
    mb.s_zero  = z;
    tick();
    mb.s_valid = 1'b0;
    mb.s_zero  = 1'b0;
  endtask

  task automatic go(input logic [7:0] np);
    mb.start       = 1'b1;
    mb.num_periods = np;
    tick();
    mb.start       = 1'b0;
  endtask

  initial begin
    mb.start = 1'b0; mb.num_periods = '0; mb.s_valid = 1'b0; mb.s_data = '0;
    mb.s_zero = 1'b0; mb.res_ready = 1'b0;
    sb.start = 1'b0; sb.num_periods = '0; sb.s_valid = 1'b0; sb.s_data = '0;
    sb.s_zero = 1'b0; sb.res_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_busy", 48'(mb.busy), 48'd0);
    chk("rst_valid", 48'(mb.res_valid), 48'd0);
    chk("rst_max", 48'(mb.res_max), 48'd0);
    chk("rst_pp", 48'(mb.res_pp), 48'd0);
    chk("rst_samples", 48'(mb.res_samples), 48'd0);
    chk("rst_ovf", 48'(mb.err_ovf), 48'd0);
    rst = 1'b0;
    tick();

    // Basic window: one period, non-marker samples in ARM discarded
    go(8'd1);
    chk("t1_busy", 48'(mb.busy), 48'd1);
    smp(16'd100, 1'b0);
    smp(16'd2, 1'b1);
    smp(16'd5, 1'b0);
    smp(16'hFFFD, 1'b0);
    smp(16'd7, 1'b0);
    smp(16'hFFF7, 1'b0);
    chk("t1_valid_pre", 48'(mb.res_valid), 48'd0);
    smp(16'd50, 1'b1);
    chk("t1_valid", 48'(mb.res_valid), 48'd1);
    chk("t1_max", 48'(mb.res_max), 48'd7);
    chk("t1_min", 48'(mb.res_min), 48'hFFF7);
    chk("t1_pp", 48'(mb.res_pp), 48'd16);
    chk("t1_samples", 48'(mb.res_samples), 48'd5);
    chk("t1_ovf", 48'(mb.err_ovf), 48'd0);
`ifdef AC_METER_MEAN_EN
    chk("t1_sum", 48'(mb.res_sum), 48'd2);
`else
    chk("t1_sum", 48'(mb.res_sum), 48'd0);
`endif
    mb.res_ready = 1'b1;
    tick();
    mb.res_ready = 1'b0;
    chk("t1_hs_valid", 48'(mb.res_valid), 48'd0);
    chk("t1_hs_busy", 48'(mb.busy), 48'd0);
    chk("t1_idle_max", 48'(mb.res_max), 48'd7);

    // Three sine periods, amplitude 1000, 20 samples each; stray start ignored
    go(8'd3);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 20; k++) begin
        if (p == 1 && k == 3) mb.start = 1'b1;
        if (p == 1 && k == 3) mb.num_periods = 8'd5;
        smp(16'(int'(1000.0 * $sin(2.0 * PI * real'(k) / 20.0))), k == 0);
        mb.start = 1'b0;
      end
    end
    chk("t2_valid_pre", 48'(mb.res_valid), 48'd0);
    smp(16'd0, 1'b1);
    chk("t2_valid", 48'(mb.res_valid), 48'd1);
    chk("t2_max", 48'(mb.res_max), 48'd1000);
    chk("t2_min", 48'(mb.res_min), 48'hFC18);
    chk("t2_pp", 48'(mb.res_pp), 48'd2000);
    chk("t2_samples", 48'(mb.res_samples), 48'd60);
    chk("t2_sum", 48'(mb.res_sum), 48'd0);
    mb.res_ready = 1'b1;
    tick();
    mb.res_ready = 1'b0;
    chk("t2_hs_busy", 48'(mb.busy), 48'd0);

    // Full-scale extremes: pp must not wrap
    go(8'd1);
    smp(16'h8000, 1'b1);
    smp(16'h7FFF, 1'b0);
    smp(16'd0, 1'b1);
    chk("t3_pp", 48'(mb.res_pp), 48'h0FFFF);
    chk("t3_max", 48'(mb.res_max), 48'h7FFF);
    chk("t3_min", 48'(mb.res_min), 48'h8000);
    chk("t3_samples", 48'(mb.res_samples), 48'd2);

    // HOLD with backpressure: samples, markers and start ignored for 10 cycles
    for (int i = 0; i < 10; i++) begin
      mb.start = (i == 4);
      mb.num_periods = 8'd1;
      smp(16'(i * 1000), i[0]);
      mb.start = 1'b0;
    end
    chk("t4_busy", 48'(mb.busy), 48'd1);
    chk("t4_valid", 48'(mb.res_valid), 48'd1);
    chk("t4_pp", 48'(mb.res_pp), 48'h0FFFF);
    chk("t4_samples", 48'(mb.res_samples), 48'd2);
    mb.res_ready = 1'b1;
    tick();
    mb.res_ready = 1'b0;
    chk("t4_hs_busy", 48'(mb.busy), 48'd0);
    chk("t4_hs_valid", 48'(mb.res_valid), 48'd0);

    // Reset mid-measurement, then zero-period start is ignored
    go(8'd2);
    smp(16'd100, 1'b1);
    smp(16'd200, 1'b0);
    chk("t5_busy_meas", 48'(mb.busy), 48'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 48'(mb.busy), 48'd0);
    chk("t5_valid", 48'(mb.res_valid), 48'd0);
    chk("t5_max", 48'(mb.res_max), 48'd0);
    chk("t5_min", 48'(mb.res_min), 48'd0);
    chk("t5_pp", 48'(mb.res_pp), 48'd0);
    chk("t5_samples", 48'(mb.res_samples), 48'd0);
    chk("t5_sum", 48'(mb.res_sum), 48'd0);
    go(8'd0);
    chk("t5_np0_busy", 48'(mb.busy), 48'd0);
    tick();
    chk("t5_np0_busy2", 48'(mb.busy), 48'd0);

    // Saturating 4-bit counter: 20 samples (1..20) in one period
    sb.start = 1'b1;
    sb.num_periods = 8'd1;
    tick();
    sb.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      sb.s_valid = 1'b1;
      sb.s_data  = 16'(k);
      sb.s_zero  = (k == 1);
      tick();
    end
    sb.s_data = 16'd99;
    sb.s_zero = 1'b1;
    tick();
    sb.s_valid = 1'b0;
    sb.s_zero  = 1'b0;
    chk("t6_valid", 48'(sb.res_valid), 48'd1);
    chk("t6_samples", 48'(sb.res_samples), 48'd15);
    chk("t6_ovf", 48'(sb.err_ovf), 48'd1);
    chk("t6_max", 48'(sb.res_max), 48'd20);
    chk("t6_min", 48'(sb.res_min), 48'd1);
    chk("t6_pp", 48'(sb.res_pp), 48'd19);
`ifdef AC_METER_MEAN_EN
    chk("t6_sum", 48'(sb.res_sum), 48'd120);
`else
    chk("t6_sum", 48'(sb.res_sum), 48'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
